// File: rtl/bus_target_ram.sv
// rtl/bus_target_ram.sv - byte-serial bus target answering ALO/AHI/DATA handshakes from an on-chip byte RAM
module bus_target_ram #(
    parameter int ADDR_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bus_strobe,
    input  logic                 bus_read,
    input  logic                 bus_write,
    input  logic [7:0]           bus_din,
    output logic [7:0]           bus_dout,
    output logic                 bus_oe,
    output logic                 bus_ack,
    input  logic                 host_we,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic [7:0]           host_wdata,
    output logic [7:0]           host_rdata,
    output logic                 host_busy,
    output logic                 txn_done,
    output logic [15:0]          txn_addr,
    output logic                 err
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {PH_ALO, PH_AHI, PH_DATA} phase_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RDRV, ST_ACK} state_t;

    phase_t phase_q, phase_d;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] stb_sync_q, rd_sync_q, wr_sync_q;
    logic                   stb_s, rd_s, wr_s;

    logic [15:0]          addr_q, addr_d;
    logic [15:0]          txn_addr_q, txn_addr_d;
    logic [7:0]           dout_q, dout_d;
    logic                 oe_q, oe_d;
    logic                 ack_q, ack_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [7:0]           host_rdata_q;

    logic [7:0]           mem [DEPTH];
    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_waddr;
    logic [7:0]           ram_wdata;
    logic                 in_range;
    logic [ADDR_BITS-1:0] ram_idx;

    // Strobe and cycle flags come from another clock domain; bus_din is trusted
    // only once the synchronised strobe is seen, since the master holds it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stb_sync_q <= '0;
            rd_sync_q  <= '0;
            wr_sync_q  <= '0;
        end else begin
            stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], bus_strobe};
            rd_sync_q  <= {rd_sync_q[SYNC_STAGES-2:0], bus_read};
            wr_sync_q  <= {wr_sync_q[SYNC_STAGES-2:0], bus_write};
        end
    end

    assign stb_s = stb_sync_q[SYNC_STAGES-1];
    assign rd_s  = rd_sync_q[SYNC_STAGES-1];
    assign wr_s  = wr_sync_q[SYNC_STAGES-1];

    assign host_busy = (phase_q != PH_ALO) || (state_q != ST_IDLE);
    assign in_range  = (addr_q[15:ADDR_BITS] == '0);
    assign ram_idx   = addr_q[ADDR_BITS-1:0];

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        addr_d     = addr_q;
        txn_addr_d = txn_addr_q;
        dout_d     = dout_q;
        oe_d       = oe_q;
        ack_d      = ack_q;
        done_d     = 1'b0;
        err_d      = err_q;
        ram_we     = 1'b0;
        ram_waddr  = host_addr;
        ram_wdata  = host_wdata;

        // Host writes only land while the bus is idle in ALO, so they can
        // never collide with the bus write below (which needs phase DATA).
        if (host_we && !host_busy) begin
            ram_we = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                ack_d = 1'b0;
                if (stb_s) begin
                    if (rd_s || wr_s) begin
                        case (phase_q)
                            PH_ALO: begin
                                addr_d[7:0] = bus_din;
                                ack_d       = 1'b1;
                                state_d     = ST_ACK;
                            end
                            PH_AHI: begin
                                addr_d[15:8] = bus_din;
                                ack_d        = 1'b1;
                                state_d      = ST_ACK;
                            end
                            default: begin
                                if (rd_s) begin
                                    dout_d  = in_range ? mem[ram_idx] : 8'hFF;
                                    oe_d    = 1'b1;
                                    state_d = ST_RDRV;
                                    if (!in_range || wr_s) begin
                                        err_d = 1'b1;
                                    end
                                end else begin
                                    if (in_range) begin
                                        ram_we    = 1'b1;
                                        ram_waddr = ram_idx;
                                        ram_wdata = bus_din;
                                    end else begin
                                        err_d = 1'b1;
                                    end
                                    ack_d   = 1'b1;
                                    state_d = ST_ACK;
                                end
                            end
                        endcase
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (phase_q != PH_ALO && !rd_s && !wr_s) begin
                    phase_d = PH_ALO;
                end
            end
            ST_RDRV: begin
                ack_d   = 1'b1;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (!stb_s) begin
                    ack_d   = 1'b0;
                    oe_d    = 1'b0;
                    state_d = ST_IDLE;
                    case (phase_q)
                        PH_ALO:  phase_d = PH_AHI;
                        PH_AHI:  phase_d = PH_DATA;
                        default: begin
                            phase_d    = PH_ALO;
                            done_d     = 1'b1;
                            txn_addr_d = addr_q;
                        end
                    endcase
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_ALO;
            addr_q       <= '0;
            txn_addr_q   <= '0;
            dout_q       <= '0;
            oe_q         <= 1'b0;
            ack_q        <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            addr_q       <= addr_d;
            txn_addr_q   <= txn_addr_d;
            dout_q       <= dout_d;
            oe_q         <= oe_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            err_q        <= err_d;
            host_rdata_q <= mem[host_addr];
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    assign bus_dout   = dout_q;
    assign bus_oe     = oe_q;
    assign bus_ack    = ack_q;
    assign txn_done   = done_q;
    assign txn_addr   = txn_addr_q;
    assign err        = err_q;
    assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_bus_target_ram.sv
// tb/tb_bus_target_ram.sv - self-checking bench for bus_target_ram
module tb_bus_target_ram;

    localparam int AB   = 8;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          bus_strobe, bus_read, bus_write;
    logic [7:0]    bus_din, bus_dout;
    logic          bus_oe, bus_ack;
    logic          host_we;
    logic [AB-1:0] host_addr;
    logic [7:0]    host_wdata, host_rdata;
    logic          host_busy, txn_done, err;
    logic [15:0]   txn_addr;

    bus_target_ram #(.ADDR_BITS(AB), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst),
        .bus_strobe(bus_strobe), .bus_read(bus_read), .bus_write(bus_write),
        .bus_din(bus_din), .bus_dout(bus_dout), .bus_oe(bus_oe), .bus_ack(bus_ack),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_busy(host_busy),
        .txn_done(txn_done), .txn_addr(txn_addr), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always @(negedge clk) if (txn_done) done_cnt++;

    logic [7:0] model [256];
    logic       err_m;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_phase(input logic rd, input logic wr, input logic [7:0] din,
                             output int lat, output logic oe_pre, output logic [7:0] dout_pre,
                             output logic oe_any);
        int d;
        bus_din = din; bus_read = rd; bus_write = wr; bus_strobe = 1'b1;
        oe_pre = 1'b0; dout_pre = 8'h00; oe_any = 1'b0; lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus_ack) begin
                lat = i;
                break;
            end
            oe_pre   = bus_oe;
            dout_pre = bus_dout;
            oe_any   = oe_any | bus_oe;
        end
        chk("ack_timeout", lat != 0, 1);
        bus_strobe = 1'b0;
        d = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!bus_ack) begin
                d = i;
                break;
            end
        end
        chk("ack_release_lat", d, SYNC + 1);
        chk("oe_release", bus_oe, 0);
    endtask

    task automatic bus_txn(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] w,
                           output logic [7:0] rdata, output int lat, output logic oe_pre,
                           output logic addr_oe);
        int l1, l2;
        logic op1, op2, oa1, oa2, oa3;
        logic [7:0] dp1, dp2;
        bus_phase(rd, wr, a[7:0], l1, op1, dp1, oa1);
        chk("alo_lat", l1, SYNC + 1);
        bus_phase(rd, wr, a[15:8], l2, op2, dp2, oa2);
        chk("ahi_lat", l2, SYNC + 1);
        bus_phase(rd, wr, w, lat, oe_pre, rdata, oa3);
        chk("data_oe", oa3, rd);
        addr_oe = oa1 | oa2 | op1 | op2;
        bus_read = 1'b0; bus_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic host_read(input logic [7:0] a, output logic [7:0] r);
        host_addr = a;
        @(negedge clk);
        r = host_rdata;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        err_m = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  rd_v;
        logic [15:0] a;
        logic [7:0]  w, expd;
        logic        is_rd, oe_pre, addr_oe, any_ack;
        int          lat, d0;

        tbl[0] = '{1'b0, 1'b1, 16'h0034, 8'hA5, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 16'h0034, 8'h00, 8'hA5, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 16'h0010, 8'h00, 8'h3E, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 16'h0005, 8'h00, 8'h5F, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 16'h00FF, 8'h01, 8'h00, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 16'h00FF, 8'h00, 8'h01, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 16'h0100, 8'h00, 8'hFF, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 16'h0105, 8'h77, 8'h00, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 16'h0005, 8'h00, 8'h5F, 1'b1};

        rst = 1'b1; bus_strobe = 0; bus_read = 0; bus_write = 0; bus_din = 0;
        host_we = 0; host_addr = 0; host_wdata = 0; err_m = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", bus_ack, 0);
        chk("rst_oe", bus_oe, 0);
        chk("rst_dout", bus_dout, 0);
        chk("rst_done", txn_done, 0);
        chk("rst_txn_addr", txn_addr, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", host_busy, 0);
        chk("rst_host_rdata", host_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Known RAM image, then the 0x10 preload used by the read vector.
        for (int i = 0; i < 256; i++) begin
            host_we = 1'b1; host_addr = 8'(i); host_wdata = 8'(i) ^ 8'h5A;
            model[i] = 8'(i) ^ 8'h5A;
            @(negedge clk);
        end
        host_addr = 8'h10; host_wdata = 8'h3E; model[16] = 8'h3E;
        @(negedge clk);
        host_we = 1'b0;
        host_read(8'h10, rd_v);
        chk("host_preload", rd_v, 8'h3E);

        for (int i = 0; i < 9; i++) begin
            d0 = done_cnt;
            bus_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd_v, lat, oe_pre, addr_oe);
            chk($sformatf("vec%0d_addr_oe", i), addr_oe, 0);
            chk($sformatf("vec%0d_err", i), err, tbl[i].exp_err);
            chk($sformatf("vec%0d_done", i), done_cnt - d0, 1);
            chk($sformatf("vec%0d_txn_addr", i), txn_addr, tbl[i].addr);
            if (tbl[i].rd) begin
                chk($sformatf("vec%0d_rd_lat", i), lat, SYNC + 2);
                chk($sformatf("vec%0d_oe_pre", i), oe_pre, 1);
                chk($sformatf("vec%0d_rdata", i), rd_v, tbl[i].exp_rdata);
            end else begin
                chk($sformatf("vec%0d_wr_lat", i), lat, SYNC + 1);
                if (tbl[i].addr < 16'h0100) model[tbl[i].addr[7:0]] = tbl[i].wdata;
            end
        end
        host_read(8'h34, rd_v);
        chk("host_after_write", rd_v, 8'hA5);

        // Reset during the ACK of the AHI phase.
        bus_phase(1'b0, 1'b1, 8'h20, lat, oe_pre, rd_v, addr_oe);
        bus_din = 8'h00; bus_strobe = 1'b1;
        any_ack = 1'b0;
        for (int i = 0; i < 40 && !any_ack; i++) begin
            @(negedge clk);
            any_ack = bus_ack;
        end
        chk("midrst_ack_seen", any_ack, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ack", bus_ack, 0);
        chk("midrst_oe", bus_oe, 0);
        chk("midrst_busy", host_busy, 0);
        chk("midrst_err", err, 0);
        rst = 1'b0; bus_strobe = 1'b0; bus_write = 1'b0; err_m = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
        d0 = done_cnt;
        bus_txn(1'b0, 1'b1, 16'h0021, 8'h99, rd_v, lat, oe_pre, addr_oe);
        model[8'h21] = 8'h99;
        chk("postrst_done", done_cnt - d0, 1);
        chk("postrst_txn_addr", txn_addr, 16'h0021);
        host_read(8'h21, rd_v);
        chk("postrst_ram", rd_v, 8'h99);

        // Abort after ALO; a host write while busy must be dropped.
        bus_phase(1'b1, 1'b0, 8'h40, lat, oe_pre, rd_v, addr_oe);
        chk("abort_busy", host_busy, 1);
        host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'hEE;
        @(negedge clk);
        host_we = 1'b0;
        bus_read = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
        chk("abort_idle", host_busy, 0);
        chk("abort_err", err, 0);
        host_read(8'h40, rd_v);
        chk("abort_host_we_ignored", rd_v, model[8'h40]);

        // Randomised traffic against the array model.
        for (int n = 0; n < 40; n++) begin
            is_rd = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(0, 255));
            w = 8'($urandom_range(0, 255));
            d0 = done_cnt;
            bus_txn(is_rd, ~is_rd, a, w, rd_v, lat, oe_pre, addr_oe);
            if (a >= 16'h0100) begin
                err_m = 1'b1;
                expd = 8'hFF;
            end else begin
                expd = model[a[7:0]];
                if (!is_rd) model[a[7:0]] = w;
            end
            if (is_rd) chk($sformatf("rand%0d_rdata", n), rd_v, expd);
            chk($sformatf("rand%0d_err", n), err, err_m);
            chk($sformatf("rand%0d_txn_addr", n), txn_addr, a);
            chk($sformatf("rand%0d_done", n), done_cnt - d0, 1);
        end

        // Read and write flags both set in DATA: read wins, no write, err.
        pulse_reset();
        chk("rw_pre_err", err, 0);
        bus_txn(1'b1, 1'b1, 16'h0034, 8'h11, rd_v, lat, oe_pre, addr_oe);
        chk("rw_rdata", rd_v, model[8'h34]);
        chk("rw_err", err, 1);
        host_read(8'h34, rd_v);
        chk("rw_no_write", rd_v, model[8'h34]);

        // Strobe with neither flag: no ack, err set.
        pulse_reset();
        bus_strobe = 1'b1; bus_read = 1'b0; bus_write = 1'b0;
        any_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            any_ack = any_ack | bus_ack;
        end
        chk("nocmd_no_ack", any_ack, 0);
        chk("nocmd_err", err, 1);
        bus_strobe = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
        chk("nocmd_idle", host_busy, 0);

        for (int i = 0; i < 256; i++) begin
            host_read(8'(i), rd_v);
            chk($sformatf("ram_%0h", i), rd_v, model[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
